pipeline_sequencer: RTL and testbench

// - Central load/flush sequencer for the 5-stage LC-3b pipeline. Drives the load enables and

---
 rtl/pipeline_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Load/flush sequencer for the 5-stage LC-3b pipeline, including the LDI/STI two-access dmem walk.
// Optional saturating performance counters are built only when PIPE_PERF_EN is defined.
module pipeline_sequencer #(
  parameter int PERF_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  imem_resp,
  input  logic                  dmem_resp,
  input  logic                  mem_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_indirect,
  input  logic                  mem_br_taken,
  input  logic                  load_use,
  output logic                  load_pc,
  output logic                  load_if_id,
  output logic                  load_id_ex,
  output logic                  load_ex_mem,
  output logic                  load_mem_wb,
  output logic                  bubble_if_id,
  output logic                  bubble_id_ex,
  output logic                  bubble_ex_mem,
  output logic                  pc_sel,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic                  dmem_phase,
  output logic [PERF_WIDTH-1:0] perf_stall,
  output logic [PERF_WIDTH-1:0] perf_flush,
  output logic [PERF_WIDTH-1:0] perf_bubble
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IND2 = 2'd1,
    HOLD = 2'd2
  } dmem_state_t;

  dmem_state_t state_reg;
  dmem_state_t state_next;

  logic mem_acc;
  logic branch_flush;
  logic dmem_done;
  logic stall;
  logic rd_next;
  logic wr_next;
  logic phase_next;

  assign mem_acc      = mem_valid & (mem_read | mem_write);
  assign branch_flush = mem_valid & mem_br_taken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rd_next    = 1'b0;
    wr_next    = 1'b0;
    phase_next = 1'b0;
    dmem_done  = ~mem_acc;

    case (state_reg)
      IDLE: begin
        // Indirect ops read the pointer first, so the first access is always a read.
        rd_next   = mem_valid & (mem_read | mem_indirect);
        wr_next   = mem_valid & mem_write & ~mem_indirect;
        dmem_done = ~mem_acc | (dmem_resp & ~mem_indirect);
        if (dmem_resp & mem_indirect) begin
          state_next = IND2;
        end else if (dmem_resp & ~imem_resp) begin
          state_next = HOLD;
        end
      end
      IND2: begin
        rd_next    = mem_read;
        wr_next    = mem_write;
        phase_next = 1'b1;
        dmem_done  = ~mem_acc | dmem_resp;
        if (dmem_resp & ~imem_resp) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        // Data side finished; only waiting for the fetch to catch up.
        dmem_done = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    stall = ~imem_resp | ~dmem_done;
    if (!stall) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    load_pc       = 1'b0;
    load_if_id    = 1'b0;
    load_id_ex    = 1'b0;
    load_ex_mem   = 1'b0;
    load_mem_wb   = 1'b0;
    bubble_if_id  = 1'b0;
    bubble_id_ex  = 1'b0;
    bubble_ex_mem = 1'b0;
    pc_sel        = 1'b0;
    dmem_read     = rd_next;
    dmem_write    = wr_next;
    dmem_phase    = phase_next;

    if (!reset_n) begin
      // Hold every stage register empty and drop any in-flight dmem request.
      bubble_if_id  = 1'b1;
      bubble_id_ex  = 1'b1;
      bubble_ex_mem = 1'b1;
      dmem_read     = 1'b0;
      dmem_write    = 1'b0;
      dmem_phase    = 1'b0;
    end else if (!stall) begin
      if (branch_flush) begin
        load_pc       = 1'b1;
        load_if_id    = 1'b1;
        load_id_ex    = 1'b1;
        load_ex_mem   = 1'b1;
        load_mem_wb   = 1'b1;
        bubble_if_id  = 1'b1;
        bubble_id_ex  = 1'b1;
        bubble_ex_mem = 1'b1;
        pc_sel        = 1'b1;
      end else if (load_use) begin
        // Freeze PC and IF/ID, let the load move on, insert one bubble behind it.
        load_id_ex    = 1'b1;
        load_ex_mem   = 1'b1;
        load_mem_wb   = 1'b1;
        bubble_id_ex  = 1'b1;
      end else begin
        load_pc       = 1'b1;
        load_if_id    = 1'b1;
        load_id_ex    = 1'b1;
        load_ex_mem   = 1'b1;
        load_mem_wb   = 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_EN
  logic [2:0]            perf_event;
  logic [PERF_WIDTH-1:0] perf_count [3];

  assign perf_event[0] = stall;
  assign perf_event[1] = ~stall & branch_flush;
  assign perf_event[2] = ~stall & ~branch_flush & load_use;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_perf
      logic [PERF_WIDTH-1:0] cnt_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else if (perf_event[gi] && (cnt_reg != {PERF_WIDTH{1'b1}})) begin
          cnt_reg <= cnt_reg + PERF_WIDTH'(1);
        end
      end

      assign perf_count[gi] = cnt_reg;
    end
  endgenerate

  assign perf_stall  = perf_count[0];
  assign perf_flush  = perf_count[1];
  assign perf_bubble = perf_count[2];
`else
  assign perf_stall  = '0;
  assign perf_flush  = '0;
  assign perf_bubble = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: vector table, directed multi-cycle sequences,
// and randomized traffic against an access-count reference model.
module tb_pipeline_sequencer;

  localparam int PW = 4;
`ifdef PIPE_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, imem_resp, dmem_resp, mem_valid, mem_read, mem_write;
  logic mem_indirect, mem_br_taken, load_use;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic bubble_if_id, bubble_id_ex, bubble_ex_mem, pc_sel;
  logic dmem_read, dmem_write, dmem_phase;
  logic [PW-1:0] perf_stall, perf_flush, perf_bubble;

  pipeline_sequencer #(.PERF_WIDTH(PW)) dut (
    .clk(clk), .reset_n(reset_n), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_indirect(mem_indirect), .mem_br_taken(mem_br_taken), .load_use(load_use),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .bubble_if_id(bubble_if_id), .bubble_id_ex(bubble_id_ex), .bubble_ex_mem(bubble_ex_mem),
    .pc_sel(pc_sel), .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_phase(dmem_phase),
    .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_bubble(perf_bubble)
  );

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  // Reference model: number of dmem accesses already completed for the MEM-stage op.
  int m_done;
  int m_cnt [3];
  bit m_adv;

  typedef struct packed {
    logic [7:0]  in;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs [0:12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int needed();
    if (mem_valid && (mem_read || mem_write)) return mem_indirect ? 2 : 1;
    return 0;
  endfunction

  function automatic bit model_stall();
    int  need = needed();
    bit  data_ok = (m_done >= need) || (dmem_resp && (m_done == need - 1));
    return !imem_resp || !data_ok;
  endfunction

  function automatic logic [11:0] model_out();
    int   need = needed();
    bit   pending = (m_done < need);
    logic rd, wr, ph;
    logic [8:0] ctl;
    if (!reset_n) return 12'b00000_111_0_000;
    rd = pending && ((mem_indirect && m_done == 0) || mem_read);
    wr = pending && mem_write && !(mem_indirect && m_done == 0);
    ph = pending && (m_done == 1);
    if (model_stall())                  ctl = 9'b00000_000_0;
    else if (mem_valid && mem_br_taken) ctl = 9'b11111_111_1;
    else if (load_use)                  ctl = 9'b00111_010_0;
    else                                ctl = 9'b11111_000_0;
    return {ctl, rd, wr, ph};
  endfunction

  task automatic model_reset();
    m_done = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_adv = 1'b1;
  endtask

  task automatic bump(input int idx);
    if (m_cnt[idx] < (1 << PW) - 1) m_cnt[idx]++;
  endtask

  task automatic model_clock();
    bit s;
    if (reset_n) begin
      s = model_stall();
      if (s) bump(0);
      else if (mem_valid && mem_br_taken) bump(1);
      else if (load_use) bump(2);
      if (!s) m_done = 0;
      else if (dmem_resp && (m_done < needed())) m_done++;
      m_adv = !s;
    end
  endtask

  task automatic set_in(input logic i, input logic d, input logic v, input logic r,
                        input logic w, input logic n, input logic b, input logic l);
    imem_resp = i; dmem_resp = d; mem_valid = v; mem_read = r;
    mem_write = w; mem_indirect = n; mem_br_taken = b; load_use = l;
  endtask

  // Called at posedge+1; compares combinational outputs and counters, then crosses one edge.
  task automatic step(input string tag);
    logic [11:0] exp, act;
    #3;
    exp = model_out();
    act = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           bubble_if_id, bubble_id_ex, bubble_ex_mem, pc_sel, dmem_read, dmem_write, dmem_phase};
    check({tag, " ctl"}, 32'(act), 32'(exp));
    check({tag, " perf_stall"},  32'(perf_stall),  PERF_ON ? 32'(m_cnt[0]) : 32'd0);
    check({tag, " perf_flush"},  32'(perf_flush),  PERF_ON ? 32'(m_cnt[1]) : 32'd0);
    check({tag, " perf_bubble"}, 32'(perf_bubble), PERF_ON ? 32'(m_cnt[2]) : 32'd0);
    if (verbose)
      $display("[%0t] %s in=%b%b%b%b%b%b%b%b rst_n=%b out=%b perf=%0d/%0d/%0d", $time, tag,
               imem_resp, dmem_resp, mem_valid, mem_read, mem_write, mem_indirect,
               mem_br_taken, load_use, reset_n, act, perf_stall, perf_flush, perf_bubble);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    step("reset");
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] act;
    //               imem,dresp,valid,rd,wr,ind,br,lu   loads_bubbles_pcsel_rd wr ph
    vecs[0]  = '{8'b1000_0000, 12'b11111_000_0_000};
    vecs[1]  = '{8'b0000_0000, 12'b00000_000_0_000};
    vecs[2]  = '{8'b1011_0000, 12'b00000_000_0_100};
    vecs[3]  = '{8'b1111_0000, 12'b11111_000_0_100};
    vecs[4]  = '{8'b1010_1000, 12'b00000_000_0_010};
    vecs[5]  = '{8'b1110_1000, 12'b11111_000_0_010};
    vecs[6]  = '{8'b1110_1100, 12'b00000_000_0_100};
    vecs[7]  = '{8'b1010_0010, 12'b11111_111_1_000};
    vecs[8]  = '{8'b1000_0001, 12'b00111_010_0_000};
    vecs[9]  = '{8'b1010_0011, 12'b11111_111_1_000};
    vecs[10] = '{8'b0010_0011, 12'b00000_000_0_000};
    vecs[11] = '{8'b1000_0010, 12'b11111_000_0_000};
    vecs[12] = '{8'b1111_0100, 12'b00000_000_0_100};

    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    step("reset state");
    step("reset state");

    for (int i = 0; i < 13; i++) begin
      reset_n = 1'b0; #1; reset_n = 1'b1;
      {imem_resp, dmem_resp, mem_valid, mem_read, mem_write,
       mem_indirect, mem_br_taken, load_use} = vecs[i].in;
      #1;
      act = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
             bubble_if_id, bubble_id_ex, bubble_ex_mem, pc_sel, dmem_read, dmem_write, dmem_phase};
      check($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
      $display("[%0t] vec%0d in=%b out=%b", $time, i, vecs[i].in, act);
      @(posedge clk); #1;
    end

    // Idle advance
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) step("idle");

    // LDR waits three cycles for dmem
    do_reset();
    set_in(1, 0, 1, 1, 0, 0, 0, 0);
    repeat (3) step("ldr wait");
    set_in(1, 1, 1, 1, 0, 0, 0, 0);
    step("ldr done");
    check("ldr perf_stall", 32'(perf_stall), PERF_ON ? 32'd3 : 32'd0);

    // STI: pointer read then indirect write
    do_reset();
    set_in(1, 0, 1, 0, 1, 1, 0, 0); step("sti c1");
    set_in(1, 1, 1, 0, 1, 1, 0, 0); step("sti c2");
    set_in(1, 0, 1, 0, 1, 1, 0, 0); step("sti c3");
    check("sti c4 phase", 32'(dmem_phase), 32'd1);
    set_in(1, 1, 1, 0, 1, 1, 0, 0); step("sti c4");

    // LDR completes while fetch still pending
    do_reset();
    set_in(0, 1, 1, 1, 0, 0, 0, 0); step("hold resp");
    set_in(0, 0, 1, 1, 0, 0, 0, 0);
    repeat (2) step("hold wait");
    set_in(1, 0, 1, 1, 0, 0, 0, 0); step("hold adv");
    set_in(1, 0, 1, 1, 0, 0, 0, 0); step("after hold");

    // Flush beats load-use
    do_reset();
    set_in(1, 0, 1, 0, 0, 0, 1, 1); step("flush+lu");
    check("flush perf_flush",  32'(perf_flush),  PERF_ON ? 32'd1 : 32'd0);
    check("flush perf_bubble", 32'(perf_bubble), 32'd0);

    // Reset in the middle of IND2
    do_reset();
    set_in(1, 1, 1, 0, 1, 1, 0, 0); step("ind2 enter");
    set_in(1, 0, 1, 0, 1, 1, 0, 0);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst mid ind2 phase", 32'(dmem_phase), 32'd0);
    check("rst mid ind2 write", 32'(dmem_write), 32'd0);
    check("rst mid ind2 bubbles", 32'({bubble_if_id, bubble_id_ex, bubble_ex_mem}), 32'd7);
    step("rst mid ind2");
    reset_n = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0); step("post rst");
    set_in(1, 0, 1, 0, 1, 1, 0, 0); step("post rst sti");

    // Randomized traffic
    verbose = 1'b0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (m_adv) begin
        mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_indirect = 1'b0; mem_br_taken = 1'b0;
        case ($urandom_range(0, 6))
          0: ;
          1: mem_valid = 1'b1;
          2: begin mem_valid = 1'b1; mem_read = 1'b1; end
          3: begin mem_valid = 1'b1; mem_write = 1'b1; end
          4: begin mem_valid = 1'b1; mem_read = 1'b1; mem_indirect = 1'b1; end
          5: begin mem_valid = 1'b1; mem_write = 1'b1; mem_indirect = 1'b1; end
          default: begin mem_valid = 1'b1; mem_br_taken = 1'b1; end
        endcase
      end
      imem_resp = ($urandom_range(0, 9) < 7);
      load_use  = ($urandom_range(0, 3) == 0);
      dmem_resp = (m_done < needed()) && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 99) == 0) begin
        reset_n = 1'b0;
        model_reset();
      end else begin
        reset_n = 1'b1;
      end
      step("rand");
    end
    $display("[%0t] random phase done, model perf=%0d/%0d/%0d", $time, m_cnt[0], m_cnt[1], m_cnt[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
